// File: rtl/lcd_link_arbiter.sv
// lcd_link_arbiter: grants a shared SPI LCD serializer to the cmd or pix channel per transaction; LCD_ARB_RR_EN enables round-robin ties
module lcd_link_arbiter #(
  parameter int GAP_CYCLES = 36,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  input  logic [7:0]       CMD_DATA,
  input  logic             CMD_DC,
  input  logic             CMD_LAST,
  output logic             CMD_READY,
  input  logic             PIX_VALID,
  input  logic [7:0]       PIX_DATA,
  input  logic             PIX_LAST,
  output logic             PIX_READY,
  output logic             TX_VALID,
  output logic [7:0]       TX_DATA,
  output logic             TX_DC,
  input  logic             TX_READY,
  input  logic             TX_IDLE,
  output logic             TX_CS_HOLD,
  output logic [1:0]       GRANT,
  output logic             ABORT,
  output logic [CNT_W-1:0] BYTE_CNT
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
  state_t state, state_n;
  logic owner;
  logic [31:0] to_cnt, gap_cnt;
  logic xfer, busy, owner_valid, owner_last, accept, timeout_hit, pick_pix;
`ifdef LCD_ARB_RR_EN
  logic rr_ptr;
`endif
  // datapath mux from the owner, handshakes and next state
  always_comb begin
    xfer        = state == XFER;
    busy        = xfer || state == DRAIN;
    owner_valid = owner ? PIX_VALID : CMD_VALID;
    owner_last  = owner ? PIX_LAST : CMD_LAST;
    TX_VALID    = xfer && owner_valid;
    TX_DATA     = owner ? PIX_DATA : CMD_DATA;
    TX_DC       = owner || CMD_DC;
    CMD_READY   = xfer && !owner && TX_READY;
    PIX_READY   = xfer && owner && TX_READY;
    GRANT       = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    TX_CS_HOLD  = busy;
    accept      = TX_VALID && TX_READY;
    timeout_hit = TIMEOUT != 0 && xfer && !owner_valid && to_cnt == 32'(TIMEOUT - 1);
`ifdef LCD_ARB_RR_EN
    pick_pix    = PIX_VALID && (!CMD_VALID || rr_ptr);
`else
    pick_pix    = !CMD_VALID;
`endif
    state_n     = (state == IDLE && (CMD_VALID || PIX_VALID)) ? XFER :
                  (xfer && ((accept && owner_last) || timeout_hit)) ? DRAIN :
                  (state == DRAIN && TX_IDLE) ? (GAP_CYCLES != 0 ? GAP : IDLE) :
                  (state == GAP && gap_cnt == 32'(GAP_CYCLES - 1)) ? IDLE : state;
  end
  // state register; reset drops CS immediately with no drain
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  // owner latch, byte counter, stall timeout, CS-high gap and abort pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner    <= 1'b0;
      BYTE_CNT <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      ABORT    <= 1'b0;
    end else begin
      ABORT   <= timeout_hit;
      gap_cnt <= state == GAP ? gap_cnt + 1 : '0;
      if (state == IDLE && state_n == XFER) begin
        owner    <= pick_pix;
        BYTE_CNT <= '0;
        to_cnt   <= '0;
      end else if (accept) begin
        if (!(&BYTE_CNT)) BYTE_CNT <= BYTE_CNT + 1'b1;
        to_cnt <= '0;
      end else if (xfer && !owner_valid) begin
        to_cnt <= timeout_hit ? '0 : to_cnt + 1;
      end
    end
  end
`ifdef LCD_ARB_RR_EN
  // favour the channel that did not own the transaction just closed
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) rr_ptr <= 1'b0;
    else if (state == DRAIN && TX_IDLE) rr_ptr <= !owner;
`endif
endmodule

// File: tb/tb_lcd_link_arbiter.sv
// tb_lcd_link_arbiter: vector table, directed corner sequences and a randomized transaction scoreboard
module tb_lcd_link_arbiter;
  localparam int GAP = 36;
  localparam int TMO = 8;
  logic CLK = 0, RESET = 1;
  logic CMD_VALID = 0, CMD_DC = 0, CMD_LAST = 0, PIX_VALID = 0, PIX_LAST = 0;
  logic [7:0] CMD_DATA = 0, PIX_DATA = 0;
  logic TX_READY = 0, TX_IDLE = 0;
  logic CMD_READY, PIX_READY, TX_VALID, TX_DC, TX_CS_HOLD, ABORT;
  logic [7:0] TX_DATA;
  logic [1:0] GRANT;
  logic [15:0] BYTE_CNT;
  lcd_link_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA), .CMD_DC(CMD_DC), .CMD_LAST(CMD_LAST), .CMD_READY(CMD_READY),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_LAST(PIX_LAST), .PIX_READY(PIX_READY),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_DC(TX_DC), .TX_READY(TX_READY), .TX_IDLE(TX_IDLE),
    .TX_CS_HOLD(TX_CS_HOLD), .GRANT(GRANT), .ABORT(ABORT), .BYTE_CNT(BYTE_CNT)
  );
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  typedef struct {
    int cv, cd, cdc, cl, pv, pd, pl, rdy, idl;
    int tv, td, tdc, crdy, prdy, g, cs, bc;
  } vec_t;
  typedef struct {int d, dc, l;} b_t;
  vec_t tbl[8];
  b_t qa[2][400];
  int qn[2], si[2], ki[2], wt[2];
  logic [7:0] pd[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask
  task automatic smp;
    @(negedge CLK);
  endtask
  task automatic wait_grant(input logic [1:0] g, output int n);
    n = 0;
    smp();
    while (GRANT !== g && n < 200) begin
      nxt();
      smp();
      n++;
    end
    chk("grant_wait", 32'(GRANT), 32'(g));
  endtask
  function automatic logic bp_rdy(input int i);
    return i == 0 || i == 3 || i == 16 || i == 19;
  endfunction

  initial begin
    int n, k, i, cyc, rel, mc, pg, own, lo, inx, pcv, ppv, ca, pa, ex, len;
    logic [1:0] g;
    //           cv cd    cdc cl pv pd    pl rdy idl  tv td    tdc crdy prdy g cs bc
    tbl[0] = '{1, 'h2A, 0, 0, 1, 'h55, 0, 1, 0,  0, 0,    0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 'h2A, 0, 0, 1, 'h55, 0, 1, 0,  1, 'h2A, 0, 1, 0, 1, 1, 0};
    tbl[2] = '{1, 'h00, 1, 0, 1, 'h55, 0, 0, 0,  1, 'h00, 1, 0, 0, 1, 1, 1};
    tbl[3] = '{1, 'h00, 1, 0, 1, 'h55, 0, 1, 0,  1, 'h00, 1, 1, 0, 1, 1, 1};
    tbl[4] = '{1, 'h01, 1, 1, 1, 'h55, 0, 1, 0,  1, 'h01, 1, 1, 0, 1, 1, 2};
    tbl[5] = '{0, 'h01, 1, 1, 1, 'h55, 0, 1, 0,  0, 0,    0, 0, 0, 1, 1, 3};
    tbl[6] = '{0, 'h01, 1, 1, 1, 'h55, 0, 1, 1,  0, 0,    0, 0, 0, 1, 1, 3};
    tbl[7] = '{0, 'h01, 1, 1, 1, 'h55, 0, 1, 0,  0, 0,    0, 0, 0, 0, 0, 3};
    pd[0] = 8'h11; pd[1] = 8'h22; pd[2] = 8'h33; pd[3] = 8'h44;
    // reset state with both channels requesting
    CMD_VALID = 1; PIX_VALID = 1; TX_READY = 1;
    smp();
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_cs", 32'(TX_CS_HOLD), 0);
    chk("rst_bc", 32'(BYTE_CNT), 0);
    chk("rst_abort", 32'(ABORT), 0);
    chk("rst_txv", 32'(TX_VALID), 0);
    chk("rst_rdy", {CMD_READY, PIX_READY}, 0);
    nxt();
    RESET = 0;
    // tie and cmd-only transaction table
    for (int r = 0; r < 8; r++) begin
      CMD_VALID = tbl[r].cv != 0; CMD_DATA = 8'(tbl[r].cd); CMD_DC = tbl[r].cdc != 0; CMD_LAST = tbl[r].cl != 0;
      PIX_VALID = tbl[r].pv != 0; PIX_DATA = 8'(tbl[r].pd); PIX_LAST = tbl[r].pl != 0;
      TX_READY = tbl[r].rdy != 0; TX_IDLE = tbl[r].idl != 0;
      smp();
      chk($sformatf("tbl%0d_txv", r), 32'(TX_VALID), tbl[r].tv);
      if (tbl[r].tv != 0) begin
        chk($sformatf("tbl%0d_data", r), 32'(TX_DATA), tbl[r].td);
        chk($sformatf("tbl%0d_dc", r), 32'(TX_DC), tbl[r].tdc);
      end
      chk($sformatf("tbl%0d_crdy", r), 32'(CMD_READY), tbl[r].crdy);
      chk($sformatf("tbl%0d_prdy", r), 32'(PIX_READY), tbl[r].prdy);
      chk($sformatf("tbl%0d_grant", r), 32'(GRANT), tbl[r].g);
      chk($sformatf("tbl%0d_cs", r), 32'(TX_CS_HOLD), tbl[r].cs);
      chk($sformatf("tbl%0d_bc", r), 32'(BYTE_CNT), tbl[r].bc);
      nxt();
    end
    // pix granted only after the gap, then backpressure including a long stall
    CMD_VALID = 0; PIX_DATA = pd[0]; PIX_LAST = 0; TX_READY = 1; TX_IDLE = 1;
    wait_grant(2'b10, n);
    chk("gap_len", 32'(n + 2 >= GAP + 1), 1);
    i = 0; k = 0;
    while (k < 4 && i < 40) begin
      chk("bp_abort", 32'(ABORT), 0);
      chk("bp_prdy", 32'(PIX_READY), 32'(TX_READY));
      chk("bp_crdy", 32'(CMD_READY), 0);
      if (TX_VALID && TX_READY) begin
        chk("bp_data", 32'(TX_DATA), 32'(pd[k]));
        chk("bp_dc", 32'(TX_DC), 1);
        k++;
      end
      nxt();
      i++;
      TX_READY = bp_rdy(i); PIX_DATA = pd[k & 3]; PIX_LAST = k == 3; PIX_VALID = k < 4;
      smp();
    end
    chk("bp_count", 32'(k), 4);
    chk("bp_bc", 32'(BYTE_CNT), 4);
    chk("bp_drain_txv", 32'(TX_VALID), 0);
    chk("bp_drain_abort", 32'(ABORT), 0);
    // timeout: one byte without LAST then the owner goes quiet
    nxt();
    CMD_VALID = 1; CMD_DATA = 8'h2C; CMD_DC = 0; CMD_LAST = 0; TX_READY = 1;
    wait_grant(2'b01, n);
    chk("to_first_txv", 32'(TX_VALID), 1);
    nxt();
    CMD_VALID = 0; TX_IDLE = 0;
    for (int j = 1; j <= TMO; j++) begin
      smp();
      chk("to_no_abort", 32'(ABORT), 0);
      chk("to_grant_held", 32'(GRANT), 1);
      nxt();
    end
    smp();
    chk("to_abort", 32'(ABORT), 1);
    chk("to_bc", 32'(BYTE_CNT), 1);
    chk("to_cs", 32'(TX_CS_HOLD), 1);
    chk("to_drain_txv", 32'(TX_VALID), 0);
    chk("to_drain_crdy", 32'(CMD_READY), 0);
    nxt();
    TX_IDLE = 1;
    smp();
    chk("to_abort_pulse", 32'(ABORT), 0);
    chk("to_cs_wait_idle", 32'(TX_CS_HOLD), 1);
    nxt();
    smp();
    chk("to_release_grant", 32'(GRANT), 0);
    chk("to_release_cs", 32'(TX_CS_HOLD), 0);
    chk("to_release_bc", 32'(BYTE_CNT), 1);
    // asynchronous reset in the middle of a long pixel burst
    nxt();
    PIX_VALID = 1; PIX_LAST = 0; PIX_DATA = 0; TX_READY = 1;
    wait_grant(2'b10, n);
    for (int b = 1; b <= 100; b++) begin
      nxt();
      PIX_DATA = 8'(b);
      smp();
    end
    chk("burst_bc", 32'(BYTE_CNT), 100);
    RESET = 1;
    #1;
    chk("arst_grant", 32'(GRANT), 0);
    chk("arst_cs", 32'(TX_CS_HOLD), 0);
    chk("arst_bc", 32'(BYTE_CNT), 0);
    chk("arst_txv", 32'(TX_VALID), 0);
    chk("arst_prdy", 32'(PIX_READY), 0);
    nxt();
    RESET = 0; PIX_VALID = 0;
    smp();
    chk("post_rst_grant0", 32'(GRANT), 0);
    nxt();
    CMD_VALID = 1; CMD_LAST = 1;
    smp();
    chk("post_rst_idle", 32'(GRANT), 0);
    nxt();
    smp();
    chk("post_rst_grant_now", 32'(GRANT), 1);
    nxt();
    RESET = 1; CMD_VALID = 0; CMD_LAST = 0;
    nxt();
    RESET = 0;
    // randomized transactions against a transaction-level scoreboard
    for (int c = 0; c < 2; c++) begin
      qn[c] = 0; si[c] = 0; ki[c] = 0; wt[c] = int'($urandom_range(0, 20));
      for (int t = 0; t < 30; t++) begin
        len = int'($urandom_range(1, 6));
        for (int b = 0; b < len; b++) begin
          qa[c][qn[c]] = '{int'($urandom_range(0, 255)), (c == 1 || b > 0) ? 1 : 0, b == len - 1 ? 1 : 0};
          qn[c]++;
        end
      end
    end
    cyc = 0; rel = -1000; mc = 0; pg = 0; own = 0; lo = 1; inx = 0; pcv = 0; ppv = 0;
    while ((ki[0] < qn[0] || ki[1] < qn[1] || pg != 0) && cyc < 20000) begin
      CMD_VALID = si[0] < qn[0] && wt[0] == 0; CMD_DATA = 8'(qa[0][si[0]].d);
      CMD_DC = qa[0][si[0]].dc != 0; CMD_LAST = qa[0][si[0]].l != 0;
      PIX_VALID = si[1] < qn[1] && wt[1] == 0; PIX_DATA = 8'(qa[1][si[1]].d); PIX_LAST = qa[1][si[1]].l != 0;
      TX_READY = $urandom_range(0, 3) != 0; TX_IDLE = $urandom_range(0, 2) == 0;
      smp();
      g = GRANT;
      if (pg == 0 && g != 0) begin
`ifdef LCD_ARB_RR_EN
        ex = (pcv != 0 && ppv != 0) ? (lo != 0 ? 1 : 2) : (pcv != 0 ? 1 : 2);
`else
        ex = pcv != 0 ? 1 : 2;
`endif
        chk("rnd_req", 32'(pcv != 0 || ppv != 0), 1);
        chk("rnd_winner", 32'(g), ex);
        chk("rnd_gap", 32'(cyc - rel >= GAP + 1), 1);
        own = g == 2'b10 ? 1 : 0; lo = own; mc = 0; inx = 1;
      end
      if (pg != 0 && g == 0) rel = cyc;
      chk("rnd_bc", 32'(BYTE_CNT), mc);
      chk("rnd_cs", 32'(TX_CS_HOLD), 32'(g != 0));
      chk("rnd_abort", 32'(ABORT), 0);
      chk("rnd_txv", 32'(TX_VALID), 32'(inx != 0 && (own != 0 ? PIX_VALID : CMD_VALID)));
      chk("rnd_crdy", 32'(CMD_READY), 32'(inx != 0 && own == 0 && TX_READY));
      chk("rnd_prdy", 32'(PIX_READY), 32'(inx != 0 && own == 1 && TX_READY));
      if (TX_VALID && TX_READY) begin
        chk("rnd_data", 32'(TX_DATA), qa[own][ki[own]].d);
        chk("rnd_dc", 32'(TX_DC), qa[own][ki[own]].dc);
        if (qa[own][ki[own]].l != 0) inx = 0;
        ki[own]++;
        mc++;
      end
      ca = (CMD_VALID && CMD_READY) ? 1 : 0;
      pa = (PIX_VALID && PIX_READY) ? 1 : 0;
      pcv = CMD_VALID ? 1 : 0; ppv = PIX_VALID ? 1 : 0; pg = int'(g); cyc++;
      nxt();
      for (int c = 0; c < 2; c++) begin
        if ((c == 0 ? ca : pa) != 0) begin
          wt[c] = qa[c][si[c]].l != 0 ? int'($urandom_range(0, 50)) : int'($urandom_range(0, 4));
          si[c]++;
        end else if (wt[c] > 0) wt[c]--;
      end
    end
    chk("rnd_done_cmd", 32'(ki[0]), 32'(qn[0]));
    chk("rnd_done_pix", 32'(ki[1]), 32'(qn[1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
